nor_op_sequencer: RTL and testbench
===================================

// Module: nor_op_sequencer
// PURPOSE
//  Operand front-end and result back-end for the 16-bit bitwise NOR unit in the datapath ALU.
//  Accepts operand words from the shared 16-bit data bus over a valid/ready handshake.
//  Builds NOR, OR, NOT and AND by driving the combinational NOR unit over 1-3 passes.
//  Registers the result with Z/N flags and holds it under a valid/ready handshake.
//  Sits between the bus operand path (upstream) and the NOR unit / result mux (downstream).
// PARAMETERS
//  WIDTH  16  datapath width; must equal the NOR unit width
// PORTS
//  Clock      in   1      rising-edge clock
//  Resetn     in   1      asynchronous, active-low reset
//  DIN        in   WIDTH  operand word from data bus
//  OP         in   2      op select, sampled with the A word: 00 NOR, 01 OR, 10 NOT A, 11 AND
//  din_valid  in   1      DIN/OP valid
//  din_ready  out  1      sequencer can accept a DIN word
//  NOR_A      out  WIDTH  registered operand A to the NOR unit
//  NOR_B      out  WIDTH  registered operand B to the NOR unit
//  NOR_X      in   WIDTH  NOR unit output (combinational from NOR_A/NOR_B)
//  RES        out  WIDTH  registered result
//  Z          out  1      RES == 0
//  N          out  1      RES[WIDTH-1]
//  res_valid  out  1      RES/Z/N valid
//  res_ready  in   1      consumer accepts the result
// BEHAVIOUR
//  Reset (Resetn low, asynchronous): state=IDLE; NOR_A, NOR_B, RES, Z, N, res_valid, pass count, internal T/U = 0.
//   - din_ready=1 as soon as Resetn is low.
//   - Reset at any point aborts the operation in flight; no partial result is ever presented.
//  Transfer: a word is consumed on the rising edge where din_valid && din_ready.
//   - The result is consumed on the rising edge where res_valid && res_ready.
//  din_ready = (state==IDLE || state==GET_B); combinational from state only, never from din_valid.
//  FSM:
//   - IDLE: on transfer, latch A=DIN and op=OP.
//     - op==10: go to EXEC directly; no B word is consumed.
//     - otherwise: go to GET_B.
//   - GET_B: on transfer, latch B=DIN and go to EXEC. Without a transfer, hold.
//   - EXEC: one NOR pass per cycle.
//     - NOR_A/NOR_B are loaded on the edge entering each pass.
//     - NOR_X is captured on the edge ending each pass.
//     - After the last pass, go to DONE.
//   - DONE: res_valid=1; RES/Z/N are held stable.
//     - On result transfer: go to IDLE and drop res_valid.
//     - res_ready while not in DONE is ignored.
//  Pass schedule (T, U are internal registers):
//   - NOR: (A,B)->RES                            1 pass
//   - NOT: (A,A)->RES                            1 pass
//   - OR:  (A,B)->T; (T,T)->RES                  2 passes
//   - AND: (A,A)->T; (B,B)->U; (T,U)->RES        3 passes
//  Latency: if the last operand transfers on edge k and the op needs P passes:
//   - RES, Z, N and res_valid update together on edge k+P.
//   - The next A can transfer no earlier than 1 cycle after the result transfer edge.
//  Z and N are computed from the NOR_X value captured on the final pass, not from stale RES.
//  NOR_A/NOR_B hold their last values in GET_B, DONE and IDLE. Consumers must not rely on them outside EXEC.
//  din_valid held high in EXEC/DONE has no effect, and DIN is not sampled.
//  No pipelining: exactly one operation in flight.
// TESTING
//  1. NOR: OP=00, A=0x00FF, B=0x0F0F -> RES=0xF000, Z=0, N=1; res_valid 1 cycle after the B edge.
//  2. AND: OP=11, A=0xFF00, B=0x0FF0 -> RES=0x0F00 on edge k+3.
//     - NOR_A/NOR_B sequence (FF00,FF00), (0FF0,0FF0), (00FF,F00F).
//  3. OR: OP=01, A=0x1234, B=0x4321 -> RES=0x5335, Z=0, N=0 on edge k+2.
//  4. NOT: OP=10, A=0xFFFF -> RES=0x0000, Z=1, N=0 on edge k+1.
//     - Only 1 bus word is consumed; the following word is taken as a new A.
//  5. Backpressure: hold res_ready=0 for 5 cycles in DONE while din_valid=1.
//     - RES/Z/N stay stable and din_ready=0.
//     - Assert res_ready: result drops after 1 edge, din_ready=1 the next cycle.
//  6. Drop Resetn mid-EXEC of an AND -> all outputs clear immediately and din_ready=1.
//     - After release, NOR 0x0000,0x0000 -> RES=0xFFFF, N=1, Z=0.

Source files
------------

// File: rtl/nor_op_sequencer.sv
// Operand/result sequencer around a combinational 16-bit NOR unit.
// Builds NOR, OR, NOT and AND from 1-3 NOR passes with valid/ready on both sides.
module nor_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] DIN,
  input  logic [1:0]       OP,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] NOR_A,
  output logic [WIDTH-1:0] NOR_B,
  input  logic [WIDTH-1:0] NOR_X,
  output logic [WIDTH-1:0] RES,
  output logic             Z,
  output logic             N,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {IDLE, GET_B, EXEC, DONE} state_e;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       pass_q, pass_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, t_q, t_d, u_q, u_d;
  logic [WIDTH-1:0] nor_a_q, nor_a_d, nor_b_q, nor_b_d, res_q, res_d;
  logic             z_q, z_d, n_q, n_d, res_valid_q, res_valid_d;
  logic [1:0]       last_pass;

  assign din_ready = (state_q == IDLE) || (state_q == GET_B);
  assign NOR_A     = nor_a_q;
  assign NOR_B     = nor_b_q;
  assign RES       = res_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign res_valid = res_valid_q;

  always_comb begin
    case (op_q)
      OP_OR:   last_pass = 2'd1;
      OP_AND:  last_pass = 2'd2;
      default: last_pass = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pass_d      = pass_q;
    a_d         = a_q;
    b_d         = b_q;
    t_d         = t_q;
    u_d         = u_q;
    nor_a_d     = nor_a_q;
    nor_b_d     = nor_b_q;
    res_d       = res_q;
    z_d         = z_q;
    n_d         = n_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          a_d    = DIN;
          op_d   = OP;
          pass_d = 2'd0;
          if (OP == OP_NOT) begin
            nor_a_d = DIN;
            nor_b_d = DIN;
            state_d = EXEC;
          end else begin
            state_d = GET_B;
          end
        end
      end
      GET_B: begin
        // First pass operands are loaded on the same edge that takes B.
        if (din_valid) begin
          b_d     = DIN;
          nor_a_d = a_q;
          nor_b_d = (op_q == OP_AND) ? a_q : DIN;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (pass_q == last_pass) begin
          res_d       = NOR_X;
          z_d         = ~|NOR_X;
          n_d         = NOR_X[WIDTH-1];
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          pass_d = pass_q + 2'd1;
          if (pass_q == 2'd0) begin
            t_d = NOR_X;
            if (op_q == OP_AND) begin
              nor_a_d = b_q;
              nor_b_d = b_q;
            end else begin
              nor_a_d = NOR_X;
              nor_b_d = NOR_X;
            end
          end else begin
            // AND final pass: U is being captured now, so feed NOR_X directly.
            u_d     = NOR_X;
            nor_a_d = t_q;
            nor_b_d = NOR_X;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      pass_q      <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      t_q         <= '0;
      u_q         <= '0;
      nor_a_q     <= '0;
      nor_b_q     <= '0;
      res_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pass_q      <= pass_d;
      a_q         <= a_d;
      b_q         <= b_d;
      t_q         <= t_d;
      u_q         <= u_d;
      nor_a_q     <= nor_a_d;
      nor_b_q     <= nor_b_d;
      res_q       <= res_d;
      z_q         <= z_d;
      n_q         <= n_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_nor_op_sequencer.sv
// Directed bench for nor_op_sequencer with a behavioural NOR unit on NOR_A/NOR_B.
module tb_nor_op_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] DIN = '0;
  logic [1:0]  OP = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] NOR_A, NOR_B, NOR_X, RES;
  logic        Z, N, res_valid;
  logic        res_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  assign NOR_X = ~(NOR_A | NOR_B);

  nor_op_sequencer #(.WIDTH(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .OP(OP), .din_valid(din_valid),
    .din_ready(din_ready), .NOR_A(NOR_A), .NOR_B(NOR_B), .NOR_X(NOR_X), .RES(RES),
    .Z(Z), .N(N), .res_valid(res_valid), .res_ready(res_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present one word and return #1 after the edge that consumed it.
  task automatic push(input logic [15:0] w, input logic [1:0] o);
    int n;
    n = 0;
    DIN = w; OP = o; din_valid = 1'b1;
    while (!din_ready && n < 50) begin
      step();
      n++;
    end
    if (!din_ready) chk("push_timeout", 32'(din_ready), 32'd1);
    step();
    din_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] r, input logic z, input logic n);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_res"}, 32'(RES), 32'(r));
    chk({tag, "_z"}, 32'(Z), 32'(z));
    chk({tag, "_n"}, 32'(N), 32'(n));
  endtask

  initial begin
    #12;
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res", 32'(RES), 32'd0);
    chk("rst_nor_a", 32'(NOR_A), 32'd0);
    chk("rst_nor_b", 32'(NOR_B), 32'd0);
    step();
    Resetn = 1'b1;
    step();

    // NOR
    push(16'h00FF, 2'b00);
    push(16'h0F0F, 2'b00);
    chk("nor_early", 32'(res_valid), 32'd0);
    chk("nor_pa", 32'(NOR_A), 32'h00FF);
    chk("nor_pb", 32'(NOR_B), 32'h0F0F);
    step();
    chk_res("nor", 16'hF000, 1'b0, 1'b1);
    consume();
    chk("nor_drop", 32'(res_valid), 32'd0);

    // AND: three passes
    push(16'hFF00, 2'b11);
    push(16'h0FF0, 2'b11);
    chk("and_p1", {NOR_A, NOR_B}, 32'hFF00FF00);
    step();
    chk("and_p2", {NOR_A, NOR_B}, 32'h0FF00FF0);
    chk("and_early1", 32'(res_valid), 32'd0);
    step();
    chk("and_p3", {NOR_A, NOR_B}, 32'h00FFF00F);
    chk("and_early2", 32'(res_valid), 32'd0);
    step();
    chk_res("and", 16'h0F00, 1'b0, 1'b0);
    consume();

    // OR: two passes
    push(16'h1234, 2'b01);
    push(16'h4321, 2'b01);
    step();
    chk("or_early", 32'(res_valid), 32'd0);
    step();
    chk_res("or", 16'h5335, 1'b0, 1'b0);
    consume();

    // NOT: one word only, next word is a fresh A
    push(16'hFFFF, 2'b10);
    chk("not_busy", 32'(din_ready), 32'd0);
    step();
    chk_res("not", 16'h0000, 1'b1, 1'b0);
    consume();
    push(16'h0F0F, 2'b00);
    chk("not_next_getb", 32'(din_ready), 32'd1);
    push(16'h00F0, 2'b00);
    step();
    chk_res("not_next", 16'hF000, 1'b0, 1'b1);
    consume();

    // Backpressure in DONE with din_valid held high
    push(16'h0001, 2'b00);
    push(16'h0002, 2'b00);
    step();
    DIN = 16'h1234; OP = 2'b10; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_res("bp", 16'hFFFC, 1'b0, 1'b1);
      chk("bp_din_ready", 32'(din_ready), 32'd0);
    end
    din_valid = 1'b0;
    consume();
    chk("bp_drop", 32'(res_valid), 32'd0);
    chk("bp_ready_again", 32'(din_ready), 32'd1);
    chk("bp_res_hold", 32'(RES), 32'hFFFC);

    // Reset mid-EXEC of AND
    push(16'hFF00, 2'b11);
    push(16'h0FF0, 2'b11);
    step();
    Resetn = 1'b0;
    #1;
    chk("mid_rst_din_ready", 32'(din_ready), 32'd1);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_nor", {NOR_A, NOR_B}, 32'd0);
    chk("mid_rst_res", {15'd0, Z, N, RES}, 32'd0);
    Resetn = 1'b1;
    step();
    push(16'h0000, 2'b00);
    push(16'h0000, 2'b00);
    step();
    chk_res("post_rst", 16'hFFFF, 1'b0, 1'b1);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
